// File: rtl/cam_box_tx.sv
// rtl/cam_box_tx.sv - crops a BOX_DIM x BOX_DIM window out of a raster camera stream
// Optional build macro CAM_BOX_INVERT_EN: forwarded pixels are inverted (255 - cam_pixel).
module cam_box_tx #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int BOX_X0  = 275,
  parameter int BOX_Y0  = 195,
  parameter int BOX_DIM = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cam_pixel,
  input  logic       cam_pixel_valid,
  input  logic       cam_sof,
  output logic [7:0] raw_pixel,
  output logic       raw_pixel_valid,
  output logic       EOF,
  output logic       frame_err
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] X_LO   = 10'(BOX_X0);
  localparam logic [9:0] X_HI   = 10'(BOX_X0 + BOX_DIM - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);
  localparam logic [8:0] Y_LO   = 9'(BOX_Y0);
  localparam logic [8:0] Y_HI   = 9'(BOX_Y0 + BOX_DIM - 1);

  if (BOX_X0 + BOX_DIM > H_RES || BOX_Y0 + BOX_DIM > V_RES) begin : g_bad_box
    $error("cam_box_tx: crop box does not fit inside the camera frame");
  end

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t     state, state_nxt;
  logic [9:0] x, x_nxt, cur_x;
  logic [8:0] y, y_nxt, cur_y;
  logic       take, in_box, last;
  logic [7:0] pix_fwd, raw_pixel_nxt;
  logic       raw_valid_nxt, eof_nxt, err_nxt;

`ifdef CAM_BOX_INVERT_EN
  assign pix_fwd = 8'd255 - cam_pixel;
`else
  assign pix_fwd = cam_pixel;
`endif

  always_comb begin
    state_nxt     = state;
    x_nxt         = x;
    y_nxt         = y;
    cur_x         = x;
    cur_y         = y;
    take          = 1'b0;
    in_box        = 1'b0;
    last          = 1'b0;
    raw_pixel_nxt = raw_pixel;
    raw_valid_nxt = 1'b0;
    eof_nxt       = 1'b0;
    err_nxt       = 1'b0;

    // A sof pixel is always (0,0); if a frame was already running it is a resync.
    if (cam_pixel_valid) begin
      if (cam_sof) begin
        take      = 1'b1;
        cur_x     = 10'd0;
        cur_y     = 9'd0;
        err_nxt   = (state == ACTIVE);
        state_nxt = ACTIVE;
      end else if (state == ACTIVE) begin
        take = 1'b1;
      end
    end

    if (take) begin
      in_box = (cur_x >= X_LO) && (cur_x <= X_HI) && (cur_y >= Y_LO) && (cur_y <= Y_HI);
      last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
      if (in_box) begin
        raw_valid_nxt = 1'b1;
        raw_pixel_nxt = pix_fwd;
      end
      if (last && !cam_sof) begin
        eof_nxt   = 1'b1;
        state_nxt = WAIT_SOF;
        x_nxt     = 10'd0;
        y_nxt     = 9'd0;
      end else if (cur_x == X_LAST) begin
        x_nxt = 10'd0;
        y_nxt = cur_y + 9'd1;
      end else begin
        x_nxt = cur_x + 10'd1;
        y_nxt = cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WAIT_SOF;
      x               <= 10'd0;
      y               <= 9'd0;
      raw_pixel       <= 8'd0;
      raw_pixel_valid <= 1'b0;
      EOF             <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      state           <= state_nxt;
      x               <= x_nxt;
      y               <= y_nxt;
      raw_pixel       <= raw_pixel_nxt;
      raw_pixel_valid <= raw_valid_nxt;
      EOF             <= eof_nxt;
      frame_err       <= err_nxt;
    end
  end

endmodule
